// File: rtl/jk_exc_driver_if.sv
// rtl/jk_exc_driver_if.sv - target request, bank feedback and J/K excitation bundle for jk_exc_driver
interface jk_exc_driver_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, busy, done, err
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_exc_driver.sv
// rtl/jk_exc_driver.sv - drives J/K excitation toward a target value, verifies the bank and retries on mismatch
// Define JK_EXC_TOGGLE_EN to drive mismatched bits as toggle (J=K=1) instead of set/clear.
module jk_exc_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input logic           clk,
  input logic           rst,
  jk_exc_driver_if.slave bus
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] j_reg, k_reg, j_n, k_n;
  logic [WIDTH-1:0] target_reg, target_n;
  logic [RW-1:0]    retry_cnt, retry_n;
  logic             done_reg, err_reg, done_n, err_n;
  logic [WIDTH-1:0] exc_t, exc_j, exc_k;

  // In IDLE the excitation is computed against the incoming request, otherwise against the latched target
  assign exc_t = (state == IDLE) ? bus.tgt_data : target_reg;

`ifdef JK_EXC_TOGGLE_EN
  assign exc_j = bus.q_fb ^ exc_t;
  assign exc_k = bus.q_fb ^ exc_t;
`else
  assign exc_j = exc_t & ~bus.q_fb;
  assign exc_k = bus.q_fb & ~exc_t;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      j_reg      <= '0;
      k_reg      <= '0;
      target_reg <= '0;
      retry_cnt  <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state      <= state_n;
      j_reg      <= j_n;
      k_reg      <= k_n;
      target_reg <= target_n;
      retry_cnt  <= retry_n;
      done_reg   <= done_n;
      err_reg    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    j_n      = '0;
    k_n      = '0;
    target_n = target_reg;
    retry_n  = retry_cnt;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tgt_valid) begin
          target_n = bus.tgt_data;
          j_n      = exc_j;
          k_n      = exc_k;
          retry_n  = '0;
          state_n  = DRIVE;
        end
      end
      DRIVE: begin
        state_n = CHECK;
      end
      CHECK: begin
        if (bus.q_fb == target_reg) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (retry_cnt < RW'(MAX_RETRY)) begin
          retry_n = retry_cnt + RW'(1);
          j_n     = exc_j;
          k_n     = exc_k;
          state_n = DRIVE;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.tgt_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.j         = j_reg;
  assign bus.k         = k_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_jk_exc_driver.sv
// tb/tb_jk_exc_driver.sv - directed bench for jk_exc_driver against a transaction-level timeline model
module tb_jk_exc_driver;
  localparam int W    = 8;
  localparam int MAXR = 3;
  localparam int ARR  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_exc_driver_if #(.WIDTH(W)) bus ();
  jk_exc_driver #(.WIDTH(W), .MAX_RETRY(MAXR)) dut (.clk(clk), .rst(rst), .bus(bus));

  // JK register bank under drive; stuck bits can never become 1
  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;
  always @(posedge clk) bank <= ((bus.j & ~bank) | (~bus.k & bank)) & ~stuck;
  assign bus.q_fb = bank;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [W-1:0] exp_j [ARR];
  bit [W-1:0] exp_k [ARR];
  bit [W-1:0] exp_q [ARR];
  bit         exp_busy [ARR];
  bit         exp_done [ARR];
  bit         exp_err  [ARR];
  logic [W-1:0] mbank = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic void excite(input logic [W-1:0] q, input logic [W-1:0] t,
                                 output logic [W-1:0] ej, output logic [W-1:0] ek);
    ej = '0;
    ek = '0;
    for (int i = 0; i < W; i++) begin
      if (q[i] != t[i]) begin
`ifdef JK_EXC_TOGGLE_EN
        ej[i] = 1'b1;
        ek[i] = 1'b1;
`else
        if (t[i]) ej[i] = 1'b1;
        else      ek[i] = 1'b1;
`endif
      end
    end
  endfunction

  // Lay out a whole transaction accepted at the end of cycle n: attempt a drives in cycle n+1+2a
  function automatic void predict(input int n, input logic [W-1:0] t);
    logic [W-1:0] vis, ej, ek;
    vis = mbank;
    for (int a = 0; a <= MAXR; a++) begin
      int d;
      d = n + 1 + 2 * a;
      if (d + 2 < ARR) begin
        excite(vis, t, ej, ek);
        exp_j[d]      = ej;
        exp_k[d]      = ek;
        exp_q[d]      = vis;
        exp_busy[d]   = 1'b1;
        exp_busy[d+1] = 1'b1;
        vis           = t & ~stuck;
        exp_q[d+1]    = vis;
        if (vis == t) begin
          exp_done[d+2] = 1'b1;
          break;
        end
        if (a == MAXR) exp_err[d+2] = 1'b1;
      end
    end
    mbank = vis;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (exp_busy[cyc]) mbank = exp_q[cyc];
      for (int i = cyc; i < ARR; i++) begin
        exp_j[i] = '0; exp_k[i] = '0; exp_q[i] = '0;
        exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
      end
    end
    chk("m_ready", {31'd0, bus.tgt_ready}, {31'd0, ~exp_busy[cyc]});
    chk("m_busy",  {31'd0, bus.busy},      {31'd0, exp_busy[cyc]});
    chk("m_j",     {24'd0, bus.j},         {24'd0, exp_j[cyc]});
    chk("m_k",     {24'd0, bus.k},         {24'd0, exp_k[cyc]});
    chk("m_done",  {31'd0, bus.done},      {31'd0, exp_done[cyc]});
    chk("m_err",   {31'd0, bus.err},       {31'd0, exp_err[cyc]});
    if (!rst && bus.tgt_valid && !exp_busy[cyc]) predict(cyc, bus.tgt_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] t);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    tick();
    bus.tgt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    tick();
    tick();
    chk("rst_j", bus.j, 0);
    chk("rst_k", bus.k, 0);
    chk("rst_ready", bus.tgt_ready, 1);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, 0);

    send(8'hA5);
    chk("a5_j", bus.j, 8'hA5);
    chk("a5_k", bus.k, 8'h00);
    tick();
    chk("a5_q", bus.q_fb, 8'hA5);
    chk("a5_chk_done", bus.done, 0);
    tick();
    chk("a5_done", bus.done, 1);
    chk("a5_err", bus.err, 0);
    chk("a5_ready", bus.tgt_ready, 1);
    tick();
    chk("a5_done_off", bus.done, 0);

    send(8'h3C);
`ifdef JK_EXC_TOGGLE_EN
    chk("3c_j", bus.j, 8'h99);
    chk("3c_k", bus.k, 8'h99);
`else
    chk("3c_j", bus.j, 8'h18);
    chk("3c_k", bus.k, 8'h81);
`endif
    tick();
    tick();
    chk("3c_done", bus.done, 1);
    tick();

    send(8'h00);
    tick();
    tick();
    chk("zero_done", bus.done, 1);
    tick();

    // Same target as the bank: passes DRIVE with nothing driven
    send(8'h00);
    chk("eq_j", bus.j, 0);
    chk("eq_busy", bus.busy, 1);
    tick();
    tick();
    chk("eq_done", bus.done, 1);
    tick();

    stuck = 8'h01;
    send(8'h01);
    for (int a = 0; a <= MAXR; a++) begin
      chk("stk_j", bus.j, 8'h01);
`ifdef JK_EXC_TOGGLE_EN
      chk("stk_k", bus.k, 8'h01);
`else
      chk("stk_k", bus.k, 8'h00);
`endif
      tick();
      chk("stk_no_done", bus.done, 0);
      tick();
    end
    chk("stk_err", bus.err, 1);
    chk("stk_done", bus.done, 0);
    tick();
    chk("stk_err_off", bus.err, 0);
    stuck = 8'h00;

    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 8'h0F;
    tick();
    bus.tgt_data = 8'hF0;
    chk("b2b_j0", bus.j, 8'h0F);
    tick();
    chk("b2b_chk_j", bus.j, 0);
    tick();
    chk("b2b_done0", bus.done, 1);
    chk("b2b_ready", bus.tgt_ready, 1);
    tick();
    bus.tgt_valid = 1'b0;
`ifdef JK_EXC_TOGGLE_EN
    chk("b2b_j1", bus.j, 8'hFF);
    chk("b2b_k1", bus.k, 8'hFF);
`else
    chk("b2b_j1", bus.j, 8'hF0);
    chk("b2b_k1", bus.k, 8'h0F);
`endif
    chk("b2b_mid_done", bus.done, 0);
    tick();
    tick();
    chk("b2b_done1", bus.done, 1);
    tick();

    send(8'h00);
    tick();
    tick();
    tick();

    send(8'hFF);
    #1;
    chk("rd_j_pre", bus.j, 8'hFF);
    rst = 1'b1;
    #1;
    chk("rd_j_rst", bus.j, 8'h00);
    chk("rd_k_rst", bus.k, 8'h00);
    chk("rd_busy_rst", bus.busy, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rd_no_done", bus.done, 0);
      chk("rd_no_err", bus.err, 0);
      tick();
    end
    chk("rd_bank_held", bus.q_fb, 8'h00);

    send(8'hFF);
    chk("post_j", bus.j, 8'hFF);
    tick();
    tick();
    chk("post_done", bus.done, 1);
    chk("post_q", bus.q_fb, 8'hFF);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jk_exc_driver.md
Name: jk_exc_driver

Overview:
Transmit-side companion for banks of JK flip-flops. Accepts a target register value over a valid/ready handshake and computes per-bit J/K excitation from the bank's current state, which is fed back on q_fb. Drives the excitation for one clock, then checks the bank. On mismatch it re-drives, up to a bounded retry count. Sits between control logic and any WIDTH-bit JK register bank built from the team's JK flip-flop cells.

Parameters:
WIDTH, 8, width of target, J, K and feedback buses
MAX_RETRY, 3, extra drive attempts after the first failed check; 0 = no retries

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
tgt_valid  input  1  target request valid
tgt_ready  output  1  block can accept target (combinational, = state IDLE)
tgt_data  input  WIDTH  desired next value of the JK bank
q_fb  input  WIDTH  current Q outputs of the driven JK bank
j  output  WIDTH  J inputs to the bank (registered)
k  output  WIDTH  K inputs to the bank (registered)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: bank reached target
err  output  1  one-cycle pulse: retries exhausted, bank != target

Behaviour:
- Reset (async): state=IDLE, j=0, k=0, done=0, err=0, retry_cnt=0, target_reg=0. Bank is held (J=K=0) while rst is high.
- Excitation function E(q,t), per bit:
  - q=t: J=0, K=0 (hold).
  - q=0, t=1: J=1, K=0 (set).
  - q=1, t=0: J=0, K=1 (clear).
  - J=K=1 is never driven unless the optional feature is enabled.
- States: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1.
  - On tgt_valid & tgt_ready: target_reg<=tgt_data, {j,k}<=E(q_fb,tgt_data), retry_cnt<=0, go DRIVE.
  - Otherwise j=k=0.
- DRIVE: lasts exactly one cycle; j/k stable. At the closing edge the bank updates; j<=0, k<=0; go CHECK.
- CHECK: compare q_fb with target_reg.
  - Equal: done<=1, go IDLE.
  - Unequal and retry_cnt<MAX_RETRY: retry_cnt++, {j,k}<=E(q_fb,target_reg), go DRIVE.
  - Unequal and retry_cnt==MAX_RETRY: err<=1, go IDLE.
- done and err are registered and high for exactly one cycle: the first IDLE cycle after CHECK. They are never high together.
- Latency, clean case: accept edge = cycle 0, DRIVE = cycle 1, CHECK = cycle 2, done high in cycle 3. tgt_ready returns in cycle 3, so the minimum period between accepts is 3 cycles.
- Each retry adds 2 cycles (DRIVE+CHECK). Worst case before err is 2*(MAX_RETRY+1) cycles after accept.
- tgt_valid while busy: ignored, not latched. The requester must hold valid until accepted.
- tgt_data equal to q_fb at accept: still passes DRIVE with j=k=0, then done.
- retry_cnt width is clog2(MAX_RETRY+1), minimum 1 bit. It never wraps.
- Reset mid-transaction: j/k forced to 0 immediately, the transaction is dropped, no done or err is issued.

Optional Feature:
Macro JK_EXC_TOGGLE_EN.
- Defined: any bit with q!=t is driven J=1, K=1 (toggle); bits with q=t are driven J=0, K=0. Retry and check logic are unchanged.
- Undefined: set/clear encoding as in Behaviour; J=K=1 is never driven.

Test Plan:
- Reset, then idle: j=0x00, k=0x00, tgt_ready=1, busy=0, done=0, err=0.
- Bank model q=0x00, send tgt=0xA5: DRIVE cycle shows j=0xA5, k=0x00; bank becomes 0xA5; done pulses in cycle 3; err stays 0.
- Bank q=0xA5, send tgt=0x3C: j=0x18, k=0x81, done pulses. With JK_EXC_TOGGLE_EN defined: j=0x99, k=0x99, done pulses.
- Bank bit0 stuck at 0, MAX_RETRY=3, send tgt=0x01: four DRIVE cycles each with j=0x01, k=0x00; err pulses at cycle 9; done never asserts.
- Hold tgt_valid high with tgt=0x0F then 0xF0 back-to-back: second request is accepted only in the cycle tgt_ready returns; two done pulses 3 cycles apart; j/k are 0 outside DRIVE.
- Assert rst during DRIVE with j=0xFF: j and k read 0x00 before the next edge; no done/err after release; the next request completes normally.
